load_unit: RTL and testbench

- Memory read path (load side) of the multicycle CPU; counterpart of the store-size writer `ss`.
- Accepts a load request (byte address, size, signedness) from the control unit over a valid/ready handshake.
- Issues a word-aligned read to the memory and selects the addressed byte or halfword lane.
- Sign- or zero-extends the result to 32 bits and returns it as a one-cycle response pulse. Misaligned requests are flagged and never reach memory.

---
 rtl/load_unit_if.sv | 28 ++
 rtl/load_unit.sv | 146 ++++++++++++++
 tb/tb_load_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_unit_if.sv
// Load-unit bus bundle: request handshake, memory read port and response.
interface load_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_misalign;
  logic              busy;

  // Requester / memory side
  modport master (
    output req_valid, req_addr, req_size, req_signed, mem_rdata,
    input  req_ready, mem_addr, rsp_valid, rsp_data, rsp_misalign, busy
  );

  // Load unit side
  modport slave (
    input  req_valid, req_addr, req_size, req_signed, mem_rdata,
    output req_ready, mem_addr, rsp_valid, rsp_data, rsp_misalign, busy
  );
endinterface

// File: rtl/load_unit.sv
// Load path of the multicycle CPU: word-aligned read, lane select,
// sign/zero extension, one-cycle response pulse; misaligned requests
// are answered directly without touching memory.
module load_unit #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic      clk,
  input  logic      reset,
  load_unit_if.slave lu
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic              sign_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       data_q;
  logic              mis_q;

  logic              accept;
  logic              req_err;
  logic              capture;
  logic [31:0]       load_data;
  logic              ready_o, busy_o, valid_o;

  assign accept  = (state_q == IDLE) && lu.req_valid;
  assign capture = (state_q == WAIT) && (cnt_q == 4'd1);

  // Alignment / reserved-size check on the incoming request
  always_comb begin
    req_err = 1'b0;
    case (lu.req_size)
      2'b00:   req_err = (lu.req_addr[1:0] != 2'b00);
      2'b01:   req_err = lu.req_addr[0];
      2'b10:   req_err = 1'b0;
      default: req_err = 1'b1;
    endcase
  end

  // Lane select and extension of the returning memory word
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = '0;
    h = '0;
    load_data = lu.mem_rdata;
    case (lane_q)
      2'd0:    b = lu.mem_rdata[7:0];
      2'd1:    b = lu.mem_rdata[15:8];
      2'd2:    b = lu.mem_rdata[23:16];
      default: b = lu.mem_rdata[31:24];
    endcase
    h = lane_q[1] ? lu.mem_rdata[31:16] : lu.mem_rdata[15:0];
    case (size_q)
      2'b01:   load_data = {{16{sign_q & h[15]}}, h};
      2'b10:   load_data = {{24{sign_q & b[7]}}, b};
      default: load_data = lu.mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lu.req_valid) state_d = req_err ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b1;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
      end
      RESP:    valid_o = 1'b1;
      default: ;
    endcase
  end

  // Latency counter next value
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !req_err)   cnt_d = 4'(MEM_LATENCY);
    else if (state_q == WAIT) cnt_d = cnt_q - 4'd1;
  end

  // Request latch, memory address, counter and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      size_q     <= '0;
      lane_q     <= '0;
      sign_q     <= 1'b0;
      mem_addr_q <= '0;
      data_q     <= '0;
      mis_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        size_q <= lu.req_size;
        lane_q <= lu.req_addr[1:0];
        sign_q <= lu.req_signed;
        if (req_err) begin
          // Error response is visible in the very next cycle
          data_q <= '0;
          mis_q  <= 1'b1;
        end else begin
          mem_addr_q <= {lu.req_addr[ADDR_W-1:2], 2'b00};
        end
      end
      if (capture) begin
        data_q <= load_data;
        mis_q  <= 1'b0;
      end
    end
  end

  assign lu.req_ready    = ready_o;
  assign lu.busy         = busy_o;
  assign lu.rsp_valid    = valid_o;
  assign lu.mem_addr     = mem_addr_q;
  assign lu.rsp_data     = data_q;
  assign lu.rsp_misalign = mis_q;

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

  logic clk;
  logic rst1, rst3;
  logic [31:0] rdata1;

  int n_tests = 0;
  int n_fail  = 0;

  load_unit_if #(.ADDR_W(32)) if1 ();
  load_unit_if #(.ADDR_W(32)) if3 ();

  load_unit #(.MEM_LATENCY(1), .ADDR_W(32)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .lu    (if1.slave)
  );

  load_unit #(.MEM_LATENCY(3), .ADDR_W(32)) dut3 (
    .clk   (clk),
    .reset (rst3),
    .lu    (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents seen by the latency-3 unit: a fixed function of the word address
  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  assign if1.mem_rdata = rdata1;
  assign if3.mem_rdata = pat(if3.mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference load: bytes per size, alignment by modulo, extension by masking
  function automatic void ref_load(input logic [31:0] addr, input logic [1:0] size,
                                   input logic sgn, input logic [31:0] word,
                                   output logic [31:0] data, output logic err);
    int nb;
    longint v, mask;
    nb = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : (size == 2'd2) ? 1 : 0;
    err = 1'b0;
    if (nb == 0) err = 1'b1;
    else if ((int'(addr[1:0]) % nb) != 0) err = 1'b1;
    data = '0;
    if (!err) begin
      v    = longint'(word) >> (8 * int'(addr[1:0]));
      mask = (longint'(1) << (8 * nb)) - 1;
      v    = v & mask;
      if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
      data = v[31:0];
    end
  endfunction

  // Issue one request to an idle unit; report response cycle (-1 = none within budget)
  task automatic issue(input int which, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, output int cyc, output logic [31:0] data,
                       output logic mis, output logic [31:0] maddr);
    bit done;
    @(negedge clk);
    if (which == 1) begin
      if1.req_valid = 1'b1; if1.req_addr = addr; if1.req_size = size; if1.req_signed = sgn;
    end else begin
      if3.req_valid = 1'b1; if3.req_addr = addr; if3.req_size = size; if3.req_signed = sgn;
    end
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0;
    if3.req_valid = 1'b0;
    cyc = -1; data = '0; mis = 1'b0; maddr = '0; done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (!done) begin
        @(negedge clk);
        if (which == 1 ? if1.rsp_valid : if3.rsp_valid) begin
          cyc   = k;
          data  = (which == 1) ? if1.rsp_data : if3.rsp_data;
          mis   = (which == 1) ? if1.rsp_misalign : if3.rsp_misalign;
          maddr = (which == 1) ? if1.mem_addr : if3.mem_addr;
          done  = 1'b1;
        end
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_mis;
    int          exp_cyc;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int cyc;
    logic [31:0] d, ma, exp_d, last_ma;
    logic m, exp_e;

    vecs[0]  = '{"word",      32'h10, 2'd0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 32'h10};
    vecs[1]  = '{"byte1_u",   32'h21, 2'd2, 1'b0, 32'h807F01FF, 32'h00000001, 1'b0, 2, 32'h20};
    vecs[2]  = '{"byte0_s",   32'h20, 2'd2, 1'b1, 32'h807F01FF, 32'hFFFFFFFF, 1'b0, 2, 32'h20};
    vecs[3]  = '{"byte3_s",   32'h23, 2'd2, 1'b1, 32'h807F01FF, 32'hFFFFFF80, 1'b0, 2, 32'h20};
    vecs[4]  = '{"byte2_s",   32'h22, 2'd2, 1'b1, 32'h807F01FF, 32'h0000007F, 1'b0, 2, 32'h20};
    vecs[5]  = '{"half1_s",   32'h42, 2'd1, 1'b1, 32'h80017FFE, 32'hFFFF8001, 1'b0, 2, 32'h40};
    vecs[6]  = '{"half1_u",   32'h42, 2'd1, 1'b0, 32'h80017FFE, 32'h00008001, 1'b0, 2, 32'h40};
    vecs[7]  = '{"half0_s",   32'h40, 2'd1, 1'b1, 32'h80017FFE, 32'h00007FFE, 1'b0, 2, 32'h40};
    vecs[8]  = '{"mis_half",  32'h41, 2'd1, 1'b1, 32'h80017FFE, 32'h00000000, 1'b1, 1, 32'h40};
    vecs[9]  = '{"mis_word",  32'h46, 2'd0, 1'b0, 32'h80017FFE, 32'h00000000, 1'b1, 1, 32'h40};
    vecs[10] = '{"mis_size3", 32'h44, 2'd3, 1'b0, 32'h80017FFE, 32'h00000000, 1'b1, 1, 32'h40};
    vecs[11] = '{"byte3_7f",  32'h13, 2'd2, 1'b1, 32'h7F000000, 32'h0000007F, 1'b0, 2, 32'h10};

    rst1 = 1'b0; rst3 = 1'b0; rdata1 = '0;
    if1.req_valid = 1'b0; if1.req_addr = '0; if1.req_size = '0; if1.req_signed = 1'b0;
    if3.req_valid = 1'b0; if3.req_addr = '0; if3.req_size = '0; if3.req_signed = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_addr", if1.mem_addr, 32'h0);
    check("rst_rsp_valid", {31'b0, if1.rsp_valid}, 32'h0);
    check("rst_rsp_data", if1.rsp_data, 32'h0);
    check("rst_misalign", {31'b0, if1.rsp_misalign}, 32'h0);
    check("rst_busy", {31'b0, if1.busy}, 32'h0);
    rst1 = 1'b1; rst3 = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, if1.req_ready}, 32'h1);
    check("rst_ready3", {31'b0, if3.req_ready}, 32'h1);

    // Directed vectors on the latency-1 unit
    foreach (vecs[i]) begin
      rdata1 = vecs[i].rdata;
      issue(1, vecs[i].addr, vecs[i].size, vecs[i].sgn, cyc, d, m, ma);
      check({vecs[i].name, "_cycle"}, 32'(cyc), 32'(vecs[i].exp_cyc));
      check({vecs[i].name, "_data"}, d, vecs[i].exp_data);
      check({vecs[i].name, "_mis"}, {31'b0, m}, {31'b0, vecs[i].exp_mis});
      check({vecs[i].name, "_maddr"}, ma, vecs[i].exp_maddr);
      @(negedge clk);
      check({vecs[i].name, "_hold"}, if1.rsp_data, vecs[i].exp_data);
      check({vecs[i].name, "_pulse"}, {31'b0, if1.rsp_valid}, 32'h0);
    end

    // Back-to-back requests on the latency-3 unit, req_valid held high
    @(negedge clk);
    if3.req_valid = 1'b1; if3.req_addr = 32'h100; if3.req_size = 2'd0; if3.req_signed = 1'b0;
    check("hs_ready_c0", {31'b0, if3.req_ready}, 32'h1);
    @(posedge clk);
    #1 if3.req_addr = 32'h104;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("hs_ready_c%0d", c), {31'b0, if3.req_ready}, {31'b0, c == 5});
      check($sformatf("hs_valid_c%0d", c), {31'b0, if3.rsp_valid}, {31'b0, c == 4});
      check($sformatf("hs_busy_c%0d", c), {31'b0, if3.busy}, {31'b0, c < 5});
      if (c == 4) check("hs_data1", if3.rsp_data, pat(32'h100));
    end
    @(posedge clk);
    #1 if3.req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("hs2_valid_c%0d", c), {31'b0, if3.rsp_valid}, {31'b0, c == 4});
      if (c == 4) check("hs_data2", if3.rsp_data, pat(32'h104));
    end

    // Reset during WAIT aborts the load
    @(negedge clk);
    if3.req_valid = 1'b1; if3.req_addr = 32'h208; if3.req_size = 2'd0;
    @(posedge clk);
    #1 if3.req_valid = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check("abort_mem_addr", if3.mem_addr, 32'h0);
    check("abort_rsp_data", if3.rsp_data, 32'h0);
    check("abort_busy", {31'b0, if3.busy}, 32'h0);
    check("abort_ready", {31'b0, if3.req_ready}, 32'h1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_valid", {31'b0, if3.rsp_valid}, 32'h0);
      if (c == 1) rst3 = 1'b1;
    end
    issue(3, 32'h30A, 2'd1, 1'b1, cyc, d, m, ma);
    ref_load(32'h30A, 2'd1, 1'b1, pat(32'h308), exp_d, exp_e);
    check("post_abort_cycle", 32'(cyc), 32'd4);
    check("post_abort_data", d, exp_d);
    check("post_abort_mis", {31'b0, m}, 32'h0);
    check("post_abort_maddr", ma, 32'h308);
    last_ma = 32'h308;

    // Randomized loads against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [1:0]  s;
      logic        sg;
      a  = $urandom;
      s  = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      ref_load(a, s, sg, pat({a[31:2], 2'b00}), exp_d, exp_e);
      issue(3, a, s, sg, cyc, d, m, ma);
      if (!exp_e) last_ma = {a[31:2], 2'b00};
      check($sformatf("rnd%0d_cycle", i), 32'(cyc), exp_e ? 32'd1 : 32'd4);
      check($sformatf("rnd%0d_data", i), d, exp_d);
      check($sformatf("rnd%0d_mis", i), {31'b0, m}, {31'b0, exp_e});
      check($sformatf("rnd%0d_maddr", i), ma, last_ma);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
